dbg_slave_cmd_queue: RTL and testbench
======================================

Name: dbg_slave_cmd_queue

Overview:
Generalised system-clock side of the CPU debug slave: takes the JTAG-domain shift register, IR and update strobes, synchronises the strobes into clk, and queues each completed DR update as a command. A consumer pops commands through a valid/ready handshake, and the block emits one-hot take_action/take_no_action pulses per IR code. Width, IR size, queue depth and synchroniser length are parameters; the previous generation handled one fixed 38-bit, 2-bit-IR command with no queueing.

Parameters:
DR_WIDTH, 38, shift register / command data width
IR_WIDTH, 2, instruction register width; NCMD = 2**IR_WIDTH decoded codes
FIFO_DEPTH, 4, command queue entries; power of two, >= 2
SYNC_STAGES, 2, synchroniser flops on vs_udr / vs_uir; >= 2
ACTION_BIT, 37, bit of the command data selecting action vs no-action; < DR_WIDTH

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ir_in  in  IR_WIDTH  JTAG IR value; stable while vs_udr is high
sr  in  DR_WIDTH  JTAG shift register; stable while vs_udr is high
vs_udr  in  1  update-DR level, asynchronous to clk
vs_uir  in  1  update-IR level, asynchronous to clk
cmd_valid  out  1  queue non-empty
cmd_ready  in  1  consumer accepts the head command
cmd_ir  out  IR_WIDTH  head command IR
cmd_data  out  DR_WIDTH  head command data
jdo  out  DR_WIDTH  last captured sr
take_action  out  NCMD  one-hot pulse: popped command with data[ACTION_BIT]=1
take_no_action  out  NCMD  one-hot pulse: popped command with data[ACTION_BIT]=0
overflow  out  1  sticky: a command was dropped

Behaviour:
- Reset (async assert, sync release): synchroniser and edge flops 0, queue empty, cmd_valid 0, jdo 0, take_action 0, take_no_action 0, overflow 0. Commands in flight are lost.
- Synchroniser: vs_udr and vs_uir each pass through SYNC_STAGES flops, plus one history flop. udr_rise/uir_rise = last stage & ~history.
- Latency: vs_udr sampled high at edge k -> udr_rise high during cycle k+SYNC_STAGES-1 -> entry visible (cmd_valid=1) after edge k+SYNC_STAGES.
- On udr_rise: jdo <= sr, always, even if the queue is full. Push {ir_in, sr} sampled in that cycle.
- Queue: first-word fall-through. cmd_ir/cmd_data show the head entry whenever cmd_valid=1. They hold the last popped value when empty.
- Pop: cmd_valid & cmd_ready. Consumer may hold cmd_ready high permanently. cmd_ready while empty is ignored.
- Full + push + pop in the same cycle: push accepted, no overflow.
- Full + push without pop: entry dropped, overflow <= 1. jdo is still updated.
- Empty + push + pop in the same cycle: no pop occurs, since cmd_valid is still 0. Push is accepted.
- overflow clears on uir_rise. If uir_rise and a dropping push occur in the same cycle, set wins.
- uir_rise does not flush the queue.
- Pulses are registered, one cycle after the pop edge, and last exactly one cycle:
  - take_action[cmd_ir] = 1 when the popped data[ACTION_BIT] = 1.
  - take_no_action[cmd_ir] = 1 when the popped data[ACTION_BIT] = 0.
  - Exactly one of the 2*NCMD bits is high per pop; all are 0 otherwise.
- Back-to-back pops give pulses on consecutive cycles.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. Full = MSBs differ and the rest are equal.
- A vs_udr high for many cycles yields one push. A glitch shorter than a clk period may be missed; that is acceptable.

Optional Feature:
DBG_SLAVE_CMD_COUNT_EN:
- Defined: adds output cmd_count [15:0], reset 0, incremented on each accepted push. It wraps 0xFFFF -> 0x0000 and does not count dropped pushes.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, cmd_valid 0.
- ir_in=2'b01, sr=38'h20_0000_1234, vs_udr pulsed 3 cycles, cmd_ready=1 -> cmd_valid for 1 cycle with cmd_ir=1, cmd_data=38'h20_0000_1234. Next cycle take_action=4'b0010, take_no_action=0. jdo=38'h20_0000_1234.
- sr with bit37=0, ir_in=3 -> take_no_action=4'b1000 single-cycle pulse.
- cmd_ready=0, 5 updates with sr=1..5 -> queue holds 1..4, overflow=1, jdo=5. Raise cmd_ready -> pops 1,2,3,4 on consecutive cycles with matching pulses. Pulse vs_uir -> overflow=0.
- Full queue, cmd_ready=1 in the same cycle as udr_rise -> no overflow, new entry is the 4th in order.
- Assert reset_n=0 with 3 entries queued -> cmd_valid=0 immediately (async). After release, a pop yields nothing until a fresh update arrives.

Source files
------------

// File: rtl/dbg_slave_cmd_queue.sv
// System-clock side of the CPU debug slave: synchronises JTAG update strobes,
// queues completed DR updates and emits per-IR action pulses on pop.
// Optional cmd_count output is enabled by defining DBG_SLAVE_CMD_COUNT_EN.
module dbg_slave_cmd_queue #(
   parameter int DR_WIDTH    = 38,
   parameter int IR_WIDTH    = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int ACTION_BIT  = 37
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [IR_WIDTH-1:0]       ir_in,
   input  logic [DR_WIDTH-1:0]       sr,
   input  logic                      vs_udr,
   input  logic                      vs_uir,
   output logic                      cmd_valid,
   input  logic                      cmd_ready,
   output logic [IR_WIDTH-1:0]       cmd_ir,
   output logic [DR_WIDTH-1:0]       cmd_data,
   output logic [DR_WIDTH-1:0]       jdo,
   output logic [(2**IR_WIDTH)-1:0]  take_action,
   output logic [(2**IR_WIDTH)-1:0]  take_no_action,
   output logic                      overflow
`ifdef DBG_SLAVE_CMD_COUNT_EN
   ,
   output logic [15:0]               cmd_count
`endif
);

   localparam int NCMD = 2**IR_WIDTH;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int PW   = AW + 1;
   localparam int EW   = IR_WIDTH + DR_WIDTH;

   logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
   logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
   logic                   udr_hist_q, udr_hist_d;
   logic                   uir_hist_q, uir_hist_d;
   logic [EW-1:0]          mem_q [FIFO_DEPTH];
   logic [EW-1:0]          mem_d [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [EW-1:0]          last_q, last_d;
   logic [DR_WIDTH-1:0]    jdo_q, jdo_d;
   logic [NCMD-1:0]        ta_q, ta_d;
   logic [NCMD-1:0]        tna_q, tna_d;
   logic                   ovf_q, ovf_d;

   logic                   udr_rise, uir_rise;
   logic                   empty, full, pop, accept, drop;
   logic [EW-1:0]          head;

   always_comb begin
      udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_hist_d = udr_sync_q[SYNC_STAGES-1];
      uir_hist_d = uir_sync_q[SYNC_STAGES-1];
      udr_rise   = udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q;
      uir_rise   = uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q;

      empty  = (wr_ptr_q == rd_ptr_q);
      full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      head   = mem_q[rd_ptr_q[AW-1:0]];
      pop    = ~empty & cmd_ready;
      // A pop in the same cycle frees the slot the push needs.
      accept = udr_rise & (~full | pop);
      drop   = udr_rise & ~accept;

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      last_d   = last_q;
      jdo_d    = jdo_q;
      ta_d     = '0;
      tna_d    = '0;
      ovf_d    = ovf_q;

      if (accept) begin
         mem_d[wr_ptr_q[AW-1:0]] = {ir_in, sr};
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (udr_rise) begin
         jdo_d = sr;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         last_d   = head;
         if (head[ACTION_BIT]) begin
            ta_d[head[EW-1:DR_WIDTH]] = 1'b1;
         end else begin
            tna_d[head[EW-1:DR_WIDTH]] = 1'b1;
         end
      end
      if (drop) begin
         ovf_d = 1'b1;
      end else if (uir_rise) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         udr_sync_q <= '0;
         uir_sync_q <= '0;
         udr_hist_q <= 1'b0;
         uir_hist_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         last_q     <= '0;
         jdo_q      <= '0;
         ta_q       <= '0;
         tna_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         udr_sync_q <= udr_sync_d;
         uir_sync_q <= uir_sync_d;
         udr_hist_q <= udr_hist_d;
         uir_hist_q <= uir_hist_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         last_q     <= last_d;
         jdo_q      <= jdo_d;
         ta_q       <= ta_d;
         tna_q      <= tna_d;
         ovf_q      <= ovf_d;
      end
   end

   // Head is shown while non-empty; the last popped entry is held otherwise.
   assign cmd_valid              = ~empty;
   assign {cmd_ir, cmd_data}     = empty ? last_q : head;
   assign jdo                    = jdo_q;
   assign take_action            = ta_q;
   assign take_no_action         = tna_q;
   assign overflow               = ovf_q;

`ifdef DBG_SLAVE_CMD_COUNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = accept ? cnt_q + 16'd1 : cnt_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cmd_count = cnt_q;
`endif

endmodule

// File: tb/tb_dbg_slave_cmd_queue.sv
// Randomised scoreboard bench for dbg_slave_cmd_queue: stimulus schedules
// expected pushes, a negedge monitor runs a queue model and compares outputs.
module tb_dbg_slave_cmd_queue;

   localparam int DRW   = 38;
   localparam int IRW   = 2;
   localparam int DEPTH = 4;
   localparam int S     = 2;
   localparam int ABIT  = 37;

   logic            clk;
   logic            reset_n;
   logic [IRW-1:0]  ir_in;
   logic [DRW-1:0]  sr;
   logic            vs_udr;
   logic            vs_uir;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [IRW-1:0]  cmd_ir;
   logic [DRW-1:0]  cmd_data;
   logic [DRW-1:0]  jdo;
   logic [3:0]      take_action;
   logic [3:0]      take_no_action;
   logic            overflow;
`ifdef DBG_SLAVE_CMD_COUNT_EN
   logic [15:0]     cmd_count;
`endif

   dbg_slave_cmd_queue #(
      .DR_WIDTH(DRW), .IR_WIDTH(IRW), .FIFO_DEPTH(DEPTH),
      .SYNC_STAGES(S), .ACTION_BIT(ABIT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
      .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
      .jdo(jdo), .take_action(take_action),
      .take_no_action(take_no_action), .overflow(overflow)
`ifdef DBG_SLAVE_CMD_COUNT_EN
      , .cmd_count(cmd_count)
`endif
   );

   typedef struct {
      int              due;
      logic [IRW-1:0]  ir;
      logic [DRW-1:0]  data;
   } pend_t;

   pend_t            pend_q[$];
   int               uir_q[$];
   int               cyc = 0;
   int               compared = 0;
   int               mismatched = 0;

   // Reference model state, owned by the monitor
   logic [IRW+DRW-1:0] mq[$];
   logic [IRW+DRW-1:0] m_last;
   logic [DRW-1:0]     m_jdo;
   logic               m_ovf;
   logic [3:0]         exp_ta;
   logic [3:0]         exp_tna;
   int                 m_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
                  name, cyc, act, exp);
      end
   endtask

   // Monitor: compare this cycle, then apply the events of the coming edge
   always @(negedge clk) begin
      logic [IRW+DRW-1:0] hd;
      logic               pop, push, uirr, drop;
      if (!reset_n) begin
         mq.delete();
         pend_q.delete();
         uir_q.delete();
         m_last  = '0;
         m_jdo   = '0;
         m_ovf   = 1'b0;
         exp_ta  = '0;
         exp_tna = '0;
         m_cnt   = 0;
      end else begin
         checkOutput("take_action", take_action, exp_ta);
         checkOutput("take_no_action", take_no_action, exp_tna);
         checkOutput("cmd_valid", cmd_valid, mq.size() != 0);
         if (mq.size() != 0) begin
            hd = mq[0];
            checkOutput("cmd_ir", cmd_ir, hd[IRW+DRW-1:DRW]);
            checkOutput("cmd_data", cmd_data, hd[DRW-1:0]);
         end else begin
            checkOutput("hold_ir", cmd_ir, m_last[IRW+DRW-1:DRW]);
            checkOutput("hold_data", cmd_data, m_last[DRW-1:0]);
         end
         checkOutput("overflow", overflow, m_ovf);
         checkOutput("jdo", jdo, m_jdo);
`ifdef DBG_SLAVE_CMD_COUNT_EN
         checkOutput("cmd_count", cmd_count, m_cnt[15:0]);
`endif
         pop     = (mq.size() != 0) && cmd_ready;
         exp_ta  = '0;
         exp_tna = '0;
         if (pop) begin
            hd     = mq.pop_front();
            m_last = hd;
            if (hd[ABIT]) exp_ta[hd[IRW+DRW-1:DRW]] = 1'b1;
            else          exp_tna[hd[IRW+DRW-1:DRW]] = 1'b1;
         end
         push = (pend_q.size() != 0) && (pend_q[0].due == cyc + 1);
         uirr = (uir_q.size() != 0) && (uir_q[0] == cyc + 1);
         drop = 1'b0;
         if (push) begin
            m_jdo = pend_q[0].data;
            if (mq.size() < DEPTH) begin
               mq.push_back({pend_q[0].ir, pend_q[0].data});
               m_cnt++;
            end else begin
               drop = 1'b1;
            end
            void'(pend_q.pop_front());
         end
         if (uirr) void'(uir_q.pop_front());
         if (drop)      m_ovf = 1'b1;
         else if (uirr) m_ovf = 1'b0;
      end
   end

   task automatic stepCycles(input int n, input bit rnd);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (rnd) cmd_ready = 1'($urandom_range(0, 1));
      end
   endtask

   // Raise vs_udr for 'hold' cycles; push lands SYNC_STAGES+1 edges later
   task automatic applyStimulus(input logic [IRW-1:0] ir, input logic [DRW-1:0] d,
                                input int hold, input bit rnd);
      pend_t p;
      ir_in  = ir;
      sr     = d;
      vs_udr = 1'b1;
      p.due  = cyc + 1 + S;
      p.ir   = ir;
      p.data = d;
      pend_q.push_back(p);
      stepCycles(hold, rnd);
      vs_udr = 1'b0;
      stepCycles(S + 2, rnd);
   endtask

   task automatic pulseUir(input bit rnd);
      vs_uir = 1'b1;
      uir_q.push_back(cyc + 1 + S);
      stepCycles(1, rnd);
      vs_uir = 1'b0;
      stepCycles(S + 2, rnd);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      pend_t          p;
      logic [DRW-1:0] d;
      reset_n   = 1'b0;
      vs_udr    = 1'b0;
      vs_uir    = 1'b0;
      ir_in     = '0;
      sr        = '0;
      cmd_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      stepCycles(10, 1'b0);

      // Single action command and single no-action command
      cmd_ready = 1'b1;
      applyStimulus(2'd1, 38'h20_0000_1234, 3, 1'b0);
      applyStimulus(2'd3, 38'h00_0000_0abc, 2, 1'b0);

      // Five updates into a four-entry queue, drain, then clear overflow
      cmd_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(IRW'($urandom_range(0, 3)), DRW'(i), 1, 1'b0);
      end
      cmd_ready = 1'b1;
      stepCycles(6, 1'b0);
      pulseUir(1'b0);

      // Full queue with a pop in the same cycle as the push
      cmd_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(IRW'(i), {1'b1, DRW'(i + 16)} , 1, 1'b0);
      end
      ir_in  = 2'd2;
      sr     = 38'h3f_1111_2222;
      vs_udr = 1'b1;
      p.due  = cyc + 1 + S;
      p.ir   = 2'd2;
      p.data = 38'h3f_1111_2222;
      pend_q.push_back(p);
      stepCycles(S, 1'b0);
      cmd_ready = 1'b1;
      stepCycles(1, 1'b0);
      vs_udr = 1'b0;
      stepCycles(8, 1'b0);

      // Asynchronous reset with entries queued
      cmd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(IRW'(i), DRW'(i + 100), 2, 1'b0);
      end
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async_reset_valid", cmd_valid, 1'b0);
      checkOutput("async_reset_jdo", jdo, '0);
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
      cmd_ready = 1'b1;
      stepCycles(5, 1'b0);
      applyStimulus(2'd0, 38'h00_dead_beef, 1, 1'b0);

      // Randomised traffic with random consumer back-pressure
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            pulseUir(1'b1);
         end else begin
            d[31:0]  = $urandom;
            d[37:32] = 6'($urandom_range(0, 63));
            applyStimulus(IRW'($urandom_range(0, 3)), d,
                          $urandom_range(1, 4), 1'b1);
         end
      end
      cmd_ready = 1'b1;
      stepCycles(10, 1'b0);

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
